// File: rtl/text_write_arbiter.sv
// Round-robin owner of the screen-buffer write port, with a built-in clear sweep.
// Optional TEXT_ARB_BLANK_GATE_EN restricts grants and sweep steps to vblank.
module text_write_arbiter #(
  parameter int width      = 128,
  parameter int height     = 48,
  parameter int char_width = 8,
  parameter int num_req    = 3,
  parameter logic [char_width-1:0] blank_char = '0,
  localparam int XW = $clog2(width),
  localparam int YW = $clog2(height),
  localparam int IW = (num_req > 1) ? $clog2(num_req) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef TEXT_ARB_BLANK_GATE_EN
  input  logic                          vblank,
`endif
  input  logic [num_req-1:0]            req_valid,
  output logic [num_req-1:0]            req_ready,
  input  logic [num_req*XW-1:0]         req_x,
  input  logic [num_req*YW-1:0]         req_y,
  input  logic [num_req*char_width-1:0] req_c,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          write_en,
  output logic [XW-1:0]                 x_w,
  output logic [YW-1:0]                 y_w,
  output logic [char_width-1:0]         c_out,
  output logic [IW-1:0]                 grant_id,
  output logic                          range_err
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic            gate_ok;
  logic            found;
  logic [IW-1:0]   g;
  logic            xfer;
  logic [XW-1:0]   sel_x;
  logic [YW-1:0]   sel_y;
  logic [char_width-1:0] sel_c;
  logic            in_range;
  logic            x_last;
  logic            last;
  int              idx;

`ifdef TEXT_ARB_BLANK_GATE_EN
  assign gate_ok = vblank;
`else
  assign gate_ok = 1'b1;
`endif

  // Scan starts one past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int k = 1; k <= num_req; k++) begin
      idx = (int'(rr_ptr) + k) % num_req;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g     = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && state == ARB && !clear_start && gate_ok && found)
      req_ready = num_req'(1) << g;
  end

  assign xfer     = |req_ready;
  assign sel_x    = req_x[g*XW +: XW];
  assign sel_y    = req_y[g*YW +: YW];
  assign sel_c    = req_c[g*char_width +: char_width];
  assign in_range = (32'(sel_x) < width) && (32'(sel_y) < height);
  assign x_last   = (cx == XW'(width - 1));
  assign last     = x_last && (cy == YW'(height - 1));

  always_comb begin
    state_n = state;
    case (state)
      ARB:     if (clear_start) state_n = CLEAR;
      CLEAR:   if (gate_ok && last) state_n = ARB;
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      rr_ptr     <= IW'(num_req - 1);
      cx         <= '0;
      cy         <= '0;
      write_en   <= 1'b0;
      x_w        <= '0;
      y_w        <= '0;
      c_out      <= '0;
      grant_id   <= '0;
      clear_busy <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      state     <= state_n;
      write_en  <= 1'b0;
      range_err <= 1'b0;
      case (state)
        ARB: begin
          if (clear_start) begin
            clear_busy <= 1'b1;
            cx         <= '0;
            cy         <= '0;
          end else if (xfer) begin
            rr_ptr <= g;
            if (in_range) begin
              write_en <= 1'b1;
              x_w      <= sel_x;
              y_w      <= sel_y;
              c_out    <= sel_c;
              grant_id <= g;
            end else begin
              range_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (gate_ok) begin
            write_en <= 1'b1;
            x_w      <= cx;
            y_w      <= cy;
            c_out    <= blank_char;
            if (x_last) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
            if (last) clear_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
